// File: rtl/md5_core_if.sv
// md5_core_if: block-in / digest-out bundle for the MD5 pipeline.
//   en        global clock enable (whole pipeline holds when low)
//   m_in      512-bit padded block, byte 0 in m_in[511:504]
//   valid_in  m_in carries a block this cycle
//   a_out..d_out  digest words (little-endian byte order)
//   m_out     block that produced the current digest
//   valid_out digest/m_out valid this cycle (qualify with en)
// master: the message generator side. slave: the core.
interface md5_core_if;
  logic         en;
  logic [511:0] m_in;
  logic         valid_in;
  logic [31:0]  a_out;
  logic [31:0]  b_out;
  logic [31:0]  c_out;
  logic [31:0]  d_out;
  logic [511:0] m_out;
  logic         valid_out;

  modport master (
    output en, m_in, valid_in,
    input  a_out, b_out, c_out, d_out, m_out, valid_out
  );

  modport slave (
    input  en, m_in, valid_in,
    output a_out, b_out, c_out, d_out, m_out, valid_out
  );
endinterface

// File: rtl/md5_core.sv
// md5_core: fully pipelined MD5 compression of one pre-padded 512-bit block
// per enabled clock. 64 round stages plus one registered IV-add stage give a
// latency of 65 enabled edges. The message rides along with its data.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (clears valid bits and outputs)
//   bus    md5_core_if.slave (en, m_in, valid_in / a..d_out, m_out, valid_out)
module md5_core (
  input  logic        clk,
  input  logic        reset,
  md5_core_if.slave   bus
);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts repeat every four rounds within each 16-round group.
  localparam int S_TAB [0:15] = '{
    7, 12, 17, 22,
    5,  9, 14, 20,
    4, 11, 16, 23,
    6, 10, 15, 21
  };

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  for (genvar i = 0; i < 64; i++) begin : g_round
    localparam int G = (i < 16) ? i :
                       (i < 32) ? (5 * i + 1) % 16 :
                       (i < 48) ? (3 * i + 5) % 16 :
                                  (7 * i) % 16;
    localparam int S = S_TAB[(i / 16) * 4 + (i % 4)];

    logic [31:0]  a_i, b_i, c_i, d_i;
    logic [511:0] m_i;
    logic         v_i;
    logic [31:0]  f, w, sum, rot;

    logic [31:0]  a_r, b_r, c_r, d_r;
    logic [511:0] m_r;
    logic         v_r;

    if (i == 0) begin : g_first
      assign a_i = IV_A;
      assign b_i = IV_B;
      assign c_i = IV_C;
      assign d_i = IV_D;
      assign m_i = bus.m_in;
      assign v_i = bus.valid_in;
    end else begin : g_rest
      assign a_i = g_round[i-1].a_r;
      assign b_i = g_round[i-1].b_r;
      assign c_i = g_round[i-1].c_r;
      assign d_i = g_round[i-1].d_r;
      assign m_i = g_round[i-1].m_r;
      assign v_i = g_round[i-1].v_r;
    end

    if (i < 16) begin : g_f0
      assign f = (b_i & c_i) | (~b_i & d_i);
    end else if (i < 32) begin : g_f1
      assign f = (d_i & b_i) | (~d_i & c_i);
    end else if (i < 48) begin : g_f2
      assign f = b_i ^ c_i ^ d_i;
    end else begin : g_f3
      assign f = c_i ^ (b_i | ~d_i);
    end

    // Message words are little-endian within the big-endian byte stream.
    assign w   = bswap(m_i[511-32*G -: 32]);
    assign sum = a_i + f + K_TAB[i] + w;
    assign rot = {sum[31-S:0], sum[31:32-S]};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        v_r <= 1'b0;
      end else if (bus.en) begin
        v_r <= v_i;
      end
    end

    // Data is don't-care while the matching valid bit is low, so it is not reset.
    always_ff @(posedge clk) begin
      if (bus.en) begin
        a_r <= d_i;
        b_r <= b_i + rot;
        c_r <= b_i;
        d_r <= c_i;
        m_r <= m_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.valid_out <= 1'b0;
      bus.a_out     <= '0;
      bus.b_out     <= '0;
      bus.c_out     <= '0;
      bus.d_out     <= '0;
      bus.m_out     <= '0;
    end else if (bus.en) begin
      bus.valid_out <= g_round[63].v_r;
      bus.a_out     <= g_round[63].a_r + IV_A;
      bus.b_out     <= g_round[63].b_r + IV_B;
      bus.c_out     <= g_round[63].c_r + IV_C;
      bus.d_out     <= g_round[63].d_r + IV_D;
      bus.m_out     <= g_round[63].m_r;
    end
  end

endmodule

// File: tb/tb_md5_core.sv
// tb_md5_core: directed test of md5_core against known MD5 digests
// (fox sentence, "Hello World", "Hello"), latency, stall, bubbles and reset.
module tb_md5_core;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  md5_core_if bus ();

  md5_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [511:0] FOX = {
    32'h54686520, 32'h71756963, 32'h6b206272, 32'h6f776e20,
    32'h666f7820, 32'h6a756d70, 32'h73206f76, 32'h65722074,
    32'h6865206c, 32'h617a7920, 32'h646f6780, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h58010000, 32'h00000000
  };
  localparam logic [511:0] HW = {
    32'h48656c6c, 32'h6f20576f, 32'h726c6480, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h58000000, 32'h00000000
  };
  localparam logic [511:0] HELLO = {
    32'h48656c6c, 32'h6f800000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h28000000, 32'h00000000
  };

  localparam logic [127:0] FOX_D   = 128'h9d7d109e_82b62b37_351dd86b_d619a442;
  localparam logic [127:0] HW_D    = 128'hb18d0ab1_4175e064_9ba9b705_e53f2ee7;
  localparam logic [127:0] HELLO_D = 128'h53991a8b_961261c4_f8ab27a8_d70478c4;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_digest(input string tag, input logic [127:0] exp);
    chk({tag, "_valid"}, {511'd0, bus.valid_out}, 512'd1);
    chk({tag, "_digest"}, {384'd0, bus.a_out, bus.b_out, bus.c_out, bus.d_out}, {384'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block, then count edges until valid_out (optionally stalling
  // en for 10 cycles once n reaches stall_at). n counts every edge from the
  // sampling edge inclusive.
  task automatic send_and_time(input logic [511:0] blk, input int stall_at, output int n);
    bit found;
    bus.m_in     = blk;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    bus.m_in     = '0;
    n     = 1;
    found = 1'b0;
    while (n < 200 && !found) begin
      if (n == stall_at) begin
        bus.en = 1'b0;
        repeat (10) begin
          tick();
          n++;
        end
        chk("stall_valid_low", {511'd0, bus.valid_out}, 512'd0);
        bus.en = 1'b1;
      end
      tick();
      n++;
      if (bus.valid_out) found = 1'b1;
    end
    chk("valid_out_seen", {511'd0, found}, 512'd1);
  endtask

  int n;
  int seen;

  initial begin
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.valid_in = 1'b0;
    bus.m_in     = '0;
    #3 reset = 1'b0;
    #1;
    chk("rst_valid_out", {511'd0, bus.valid_out}, 512'd0);
    chk("rst_abcd", {384'd0, bus.a_out, bus.b_out, bus.c_out, bus.d_out}, 512'd0);
    chk("rst_m_out", bus.m_out, 512'd0);
    #20 reset = 1'b1;
    tick();

    // Single fox block: latency, digest, message passthrough, one-cycle pulse.
    send_and_time(FOX, 0, n);
    chk("fox_latency", 512'(n), 512'd65);
    chk_digest("fox", FOX_D);
    chk("fox_m_out", bus.m_out, FOX);
    tick();
    chk("fox_pulse_end", {511'd0, bus.valid_out}, 512'd0);

    // Back-to-back three blocks.
    bus.valid_in = 1'b1;
    bus.m_in = FOX;   tick();
    bus.m_in = HW;    tick();
    bus.m_in = HELLO; tick();
    bus.valid_in = 1'b0;
    bus.m_in = '0;
    repeat (61) tick();
    chk("b2b_early", {511'd0, bus.valid_out}, 512'd0);
    tick();
    chk_digest("b2b_fox", FOX_D);
    tick();
    chk_digest("b2b_hw", HW_D);
    chk("b2b_hw_m_out", bus.m_out, HW);
    tick();
    chk_digest("b2b_hello", HELLO_D);
    chk("b2b_hello_m_out", bus.m_out, HELLO);
    tick();
    chk("b2b_end", {511'd0, bus.valid_out}, 512'd0);

    // Enable stall of 10 cycles mid-pipeline.
    send_and_time(FOX, 30, n);
    chk("stall_latency", 512'(n), 512'd75);
    chk_digest("stall_fox", FOX_D);

    // Bubble pattern 1,0,1 with an all-zero bubble block.
    repeat (3) tick();
    bus.valid_in = 1'b1; bus.m_in = FOX;   tick();
    bus.valid_in = 1'b0; bus.m_in = '0;    tick();
    bus.valid_in = 1'b1; bus.m_in = HELLO; tick();
    bus.valid_in = 1'b0; bus.m_in = '0;
    repeat (62) tick();
    chk_digest("bub_fox", FOX_D);
    tick();
    chk("bub_gap", {511'd0, bus.valid_out}, 512'd0);
    tick();
    chk_digest("bub_hello", HELLO_D);
    tick();
    chk("bub_end", {511'd0, bus.valid_out}, 512'd0);

    // Reset mid-stream: one digest on the outputs, three blocks in flight.
    repeat (3) tick();
    bus.valid_in = 1'b1;
    bus.m_in = FOX;   tick();
    bus.m_in = HW;    tick();
    bus.m_in = HELLO; tick();
    bus.m_in = FOX;   tick();
    bus.valid_in = 1'b0;
    bus.m_in = '0;
    repeat (61) tick();
    chk_digest("pre_rst_fox", FOX_D);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid_out", {511'd0, bus.valid_out}, 512'd0);
    chk("mid_rst_abcd", {384'd0, bus.a_out, bus.b_out, bus.c_out, bus.d_out}, 512'd0);
    chk("mid_rst_m_out", bus.m_out, 512'd0);
    #3 reset = 1'b1;
    seen = 0;
    repeat (100) begin
      tick();
      if (bus.valid_out) seen++;
    end
    chk("post_rst_no_valid", 512'(seen), 512'd0);
    send_and_time(HELLO, 0, n);
    chk("post_rst_latency", 512'(n), 512'd65);
    chk_digest("post_rst_hello", HELLO_D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_core.md
Name: md5_core

Overview:
- Fully pipelined MD5 compression core for a single pre-padded 512-bit block. It accepts one block per enabled clock and produces the 128-bit digest, IV already added, as four 32-bit words.
- The input message travels alongside the data so downstream logic can identify which candidate produced a digest.
- The core sits behind a message generator in the hash-search datapath.

Parameters:
- None. All constants (IV, the 64 K constants, rotate amounts) are fixed per RFC 1321.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  global clock enable; when 0 the whole pipeline holds.
- m_in  input  512  padded message block; m_in[511:504] is message byte 0, m_in[7:0] is byte 63.
- valid_in  input  1  m_in is a valid block this cycle; sampled only when en=1.
- a_out  output  32  digest word A.
- b_out  output  32  digest word B.
- c_out  output  32  digest word C.
- d_out  output  32  digest word D.
- m_out  output  512  copy of the m_in that produced the current digest, same byte layout.
- valid_out  output  1  a_out..d_out and m_out are valid this cycle.

Behaviour:
- Word extraction: MD5 word M[i] (i=0..15) is the little-endian value of bytes 4i..4i+3, i.e. byte-swap of m_in[511-32i -: 32]. Example: m_in[511:480]=0x54686520 gives M[0]=0x20656854.
- Digest words are little-endian too: the digest byte string is a_out byte-swapped, then b_out, then c_out, then d_out.
- Pipeline structure:
  - 64 round stages, one MD5 round per stage, then one registered final-add stage.
  - Each round stage registers {A,B,C,D, 512-bit message, valid}.
  - Round i computes F per group: i<16 F=(B&C)|(~B&D), g=i; i<32 F=(D&B)|(~D&C), g=(5i+1)%16; i<48 F=B^C^D, g=(3i+5)%16; else F=C^(B|~D), g=(7i)%16.
  - Round update: newB = B + rotl(A+F+K[i]+M[g], s[i]); newA=D, newD=C, newC=B. All adds are mod 2^32.
- IV and final add:
  - Stage 0 starts from IV A=0x67452301, B=0xefcdab89, C=0x98badcfe, D=0x10325476.
  - The final stage adds the IV to the round-63 result word-wise, mod 2^32, and registers the outputs.
- Latency: exactly 65 enabled clock edges from the edge that samples valid_in=1 to valid_out=1 with the matching digest.
- Throughput: 1 block per enabled cycle. Back-to-back inputs produce back-to-back outputs in the same order.
- valid propagates with its data. Bubbles (valid_in=0) propagate as valid_out=0. Data registers may hold don't-care values in bubbles, but valid bits must be exact.
- en=0: every pipeline register, including outputs, holds. valid_out holds its previous value, and downstream must qualify it with en.
- Reset (reset=0, asynchronous): every valid bit and all outputs clear to 0 immediately, including a_out..d_out=0, m_out=0 and valid_out=0.
  - In-flight blocks are discarded.
  - After reset is released, the first valid_out can appear no earlier than 65 enabled edges after a new valid_in.
- No backpressure; outputs are not held beyond one enabled cycle unless en=0.

Test Plan:
- Reset: assert reset=0 mid-stream with 3 blocks in flight -> all outputs 0 at once; no valid_out afterwards until new input.
- "The quick brown fox jumps over the lazy dog": m_in words 54686520 71756963 6b206272 6f776e20 666f7820 6a756d70 73206f76 65722074 6865206c 617a7920 646f6780 0 0 0 58010000 0. After 65 edges -> a=9d7d109e, b=82b62b37, c=351dd86b, d=d619a442, i.e. digest 9e107d9d372bb6826bd81d3542a419d6. m_out equals m_in.
- Back-to-back: fox block, then "Hello World" (48656c6c 6f20576f 726c6480 0…0 58000000 0), then "Hello" (48656c6c 6f800000 0…0 28000000 0) on consecutive cycles. Expect three consecutive valid_out pulses in order:
  - fox digest as above.
  - a=b18d0ab1, b=4175e064, c=9ba9b705, d=e53f2ee7.
  - a=53991a8b, b=961261c4, c=f8ab27a8, d=d70478c4.
- Enable stall: drop en for 10 cycles while the fox block is at stage 30 -> valid_out arrives 10 cycles later with an unchanged digest.
- Bubbles: valid_in pattern 1,0,1 -> valid_out pattern 1,0,1 at latency 65. The all-zero bubble block never asserts valid_out.
